raster_stream_gen: RTL and testbench
====================================

// Module: raster_stream_gen
// PURPOSE
// Sensor-side raster transmitter for the edge-detection pipeline: emits vvalid/hvalid/dout pixel stream in
// the exact format consumed by the line buffers (nline3_buffer din/dx/dy/grad, hvalid, vvalid).
// Synthesizable pattern source for bring-up and regression without a real sensor; sits at pipeline head.
// PARAMETERS
// H_ACT     1920  active pixels per line
// V_ACT     1080  active lines per frame
// H_BLANK   280   horizontal blanking clocks (line front porch and inter-line gap)
// V_BLANK   45    vertical blanking, in line periods of (H_ACT+H_BLANK) clocks
// DW        8     pixel width, 1..16
// CHK_LOG2  3     checkerboard square size = 2**CHK_LOG2 pixels
// PORTS
// clk        in   1       pixel clock
// rst        in   1       synchronous reset, active-high
// en         in   1       run request; sampled at frame boundaries only
// pat_sel    in   2       0 h-ramp, 1 v-ramp, 2 checker, 3 PRBS; latched at frame start
// vvalid     out  1       frame-valid, high from frame front porch through last active pixel
// hvalid     out  1       pixel-valid, high exactly H_ACT clocks per active line
// dout       out  DW      pixel data; 0 whenever hvalid=0
// frame_done out  1       one-clock pulse, first clock after last active pixel of frame
// busy       out  1       high in every state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, hcnt=vcnt=0, LFSR=16'hACE1. rst mid-frame aborts frame: outputs 0 next clock.
// - All outputs registered. States and output per clock spent there:
//   IDLE   : vvalid=0, hvalid=0. en=1 -> FRONT.
//   FRONT  : vvalid=1, hvalid=0, H_BLANK clocks; latch pat_sel, reset LFSR to seed, vcnt=0 -> ACTIVE.
//   ACTIVE : vvalid=1, hvalid=1, H_ACT clocks, hcnt 0..H_ACT-1. End: vcnt<V_ACT-1 -> HBLANK, else -> VBLANK.
//   HBLANK : vvalid=1, hvalid=0, H_BLANK clocks; vcnt+=1 -> ACTIVE.
//   VBLANK : vvalid=0, hvalid=0, V_BLANK*(H_ACT+H_BLANK) clocks; frame_done=1 on its first clock.
//            End: en=1 -> FRONT, else -> IDLE.
// - Latency: en high at edge k in IDLE -> vvalid=1 after edge k+1; first hvalid after edge k+1+H_BLANK.
// - Frame period (continuous en): H_BLANK + V_ACT*H_ACT + (V_ACT-1)*H_BLANK + V_BLANK*(H_ACT+H_BLANK) clocks.
// - en deassert mid-frame: current frame completes fully (incl. VBLANK, frame_done), then IDLE.
// - pat_sel changes mid-frame ignored until next FRONT.
// - dout (hvalid=1): pat0 = hcnt[DW-1:0] (wraps mod 2**DW); pat1 = vcnt[DW-1:0];
//   pat2 = (hcnt[CHK_LOG2]^vcnt[CHK_LOG2]) ? {DW{1'b1}} : 0;
//   pat3 = lfsr[15 -: DW]; Fibonacci x^16+x^14+x^13+x^11+1, shift once after every active pixel, seeded per frame.
// - hcnt/vcnt widths = $clog2 of H_ACT/V_ACT (min 1); no overflow beyond terminal counts.
// - Degenerate params (H_BLANK=0 or V_BLANK=0): corresponding state skipped (0 clocks); V_BLANK=0 -> frame_done
//   asserted on same clock as FRONT/IDLE entry.
// TESTING (bench params H_ACT=8, V_ACT=4, H_BLANK=4, V_BLANK=2, DW=8, CHK_LOG2=1)
// 1 rst 5 clk, en=1 pat=0 -> vvalid up 1 clk after en, hvalid after 4 more; 4 lines dout 0..7; 4-clk gaps;
//   frame_done once; frame period 4+32+12+24=72 clk, second frame starts immediately.
// 2 pat=2 -> line0: 00,00,FF,FF,00,00,FF,FF; line1 same; line2 inverted; line3 inverted.
// 3 pat=3, two frames -> first pixel each frame 0xAC; both frames' 32-pixel sequences identical.
// 4 en=1 one clk then 0 mid line 1 -> full frame still produced, frame_done, then busy=0, vvalid=0 held.
// 5 rst pulse during ACTIVE line 2, en held -> next clk all outputs 0; after release new FRONT, dout restarts at 0.
// 6 pat_sel 0->1 during line 1 -> frame stays h-ramp; next frame v-ramp (dout = line index 0..3).

Source files
------------

// File: rtl/raster_stream_gen_if.sv
// Pixel-stream bundle between the raster pattern source and its consumer.
//   en         run request into the generator
//   pat_sel    pattern select into the generator (0 h-ramp, 1 v-ramp, 2 checker, 3 PRBS)
//   vvalid     frame-valid from the generator
//   hvalid     pixel-valid from the generator
//   dout       pixel data from the generator, zero outside hvalid
//   frame_done one-clock end-of-frame pulse from the generator
//   busy       generator is not idle
// master = generator side, slave = consumer/controller side.
interface raster_stream_gen_if #(
  parameter int DW = 8
);
  logic          en;
  logic [1:0]    pat_sel;
  logic          vvalid;
  logic          hvalid;
  logic [DW-1:0] dout;
  logic          frame_done;
  logic          busy;

  modport master (
    input  en, pat_sel,
    output vvalid, hvalid, dout, frame_done, busy
  );

  modport slave (
    output en, pat_sel,
    input  vvalid, hvalid, dout, frame_done, busy
  );
endinterface

// File: rtl/raster_stream_gen.sv
// Synthesizable raster test-pattern source for the head of the edge-detection
// pipeline. Emits a vvalid/hvalid/dout stream in the format the line buffers
// expect, with selectable h-ramp, v-ramp, checkerboard or PRBS content.
// Ports:
//   clk  pixel clock
//   rst  synchronous active-high reset; aborts any frame in progress
//   bus  raster_stream_gen_if.master (en, pat_sel in; vvalid, hvalid, dout,
//        frame_done, busy out). All outputs are registered.
// Frame shape: FRONT (H_BLANK) then V_ACT lines of H_ACT active clocks separated
// by H_BLANK gaps, then VBLANK of V_BLANK line periods. en and pat_sel are only
// looked at when a frame is about to start.
module raster_stream_gen #(
  parameter int H_ACT    = 1920,
  parameter int V_ACT    = 1080,
  parameter int H_BLANK  = 280,
  parameter int V_BLANK  = 45,
  parameter int DW       = 8,
  parameter int CHK_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  raster_stream_gen_if.master   bus
);

  localparam int HW      = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int VW      = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int VB_CLKS = V_BLANK * (H_ACT + H_BLANK);
  localparam int TMAX    = (H_BLANK > VB_CLKS) ? H_BLANK : VB_CLKS;
  localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRONT  = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } state_t;

  // Zero-length blanking collapses the corresponding state out of the path.
  localparam state_t ENTRY_ST = (H_BLANK == 0) ? ACTIVE : FRONT;
  localparam state_t GAP_ST   = (H_BLANK == 0) ? ACTIVE : HBLANK;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form; pixels take the top bits.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Counters are widened first so DW or CHK_LOG2 larger than the counter width
  // simply read zero-extended bits.
  function automatic logic [DW-1:0] pixel(input logic [1:0]    pat,
                                          input logic [HW-1:0] h,
                                          input logic [VW-1:0] v,
                                          input logic [15:0]   lfsr);
    logic [31:0] h32;
    logic [31:0] v32;
    h32 = 32'(h);
    v32 = 32'(v);
    case (pat)
      2'd0:    pixel = h32[DW-1:0];
      2'd1:    pixel = v32[DW-1:0];
      2'd2:    pixel = (h32[CHK_LOG2] ^ v32[CHK_LOG2]) ? {DW{1'b1}} : '0;
      default: pixel = lfsr[15 -: DW];
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic [1:0]      pat_q;
  logic [15:0]     lfsr_q;
  logic            start;
  logic            last_pix;
  logic            t_last_h, t_last_v, h_last, v_last;

  logic            vvalid_p1;
  logic            vld_p1;
  logic [DW-1:0]   dout_p1;
  logic            busy_p1;
  logic            done_p1;
  logic            frame_done_p2;

  assign t_last_h = (tcnt_q == TW'(H_BLANK - 1));
  assign t_last_v = (tcnt_q == TW'(VB_CLKS - 1));
  assign h_last   = (hcnt_q == HW'(H_ACT - 1));
  assign v_last   = (vcnt_q == VW'(V_ACT - 1));

  always_comb begin
    state_d  = state_q;
    tcnt_d   = '0;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    start    = 1'b0;
    last_pix = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          start   = 1'b1;
          state_d = ENTRY_ST;
        end
      end
      FRONT, HBLANK: begin
        if (t_last_h) state_d = ACTIVE;
        else          tcnt_d  = tcnt_q + TW'(1);
      end
      ACTIVE: begin
        if (!h_last) begin
          hcnt_d = hcnt_q + HW'(1);
        end else begin
          hcnt_d = '0;
          if (!v_last) begin
            vcnt_d  = vcnt_q + VW'(1);
            state_d = GAP_ST;
          end else begin
            last_pix = 1'b1;
            if (VB_CLKS != 0) begin
              state_d = VBLANK;
            end else if (bus.en) begin
              start   = 1'b1;
              state_d = ENTRY_ST;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      VBLANK: begin
        if (t_last_v) begin
          if (bus.en) begin
            start   = 1'b1;
            state_d = ENTRY_ST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end
  end

  // ---- p0: raster state, counters, pattern latch and LFSR ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pat_q   <= 2'd0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      if (start) begin
        pat_q  <= bus.pat_sel;
        lfsr_q <= SEED;
      end else if (state_q == ACTIVE) begin
        lfsr_q <= lfsr_step(lfsr_q);
      end
    end
  end

  // ---- p1: registered stream outputs; p2: end-of-frame pulse one clock after last pixel ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vvalid_p1     <= 1'b0;
      vld_p1        <= 1'b0;
      dout_p1       <= '0;
      busy_p1       <= 1'b0;
      done_p1       <= 1'b0;
      frame_done_p2 <= 1'b0;
    end else begin
      vvalid_p1     <= (state_q == FRONT) || (state_q == ACTIVE) || (state_q == HBLANK);
      vld_p1        <= (state_q == ACTIVE);
      dout_p1       <= (state_q == ACTIVE) ? pixel(pat_q, hcnt_q, vcnt_q, lfsr_q) : '0;
      busy_p1       <= (state_q != IDLE);
      done_p1       <= last_pix;
      frame_done_p2 <= done_p1;
    end
  end

  assign bus.vvalid     = vvalid_p1;
  assign bus.hvalid     = vld_p1;
  assign bus.dout       = dout_p1;
  assign bus.busy       = busy_p1;
  assign bus.frame_done = frame_done_p2;

endmodule

// File: tb/tb_raster_stream_gen.sv
// Directed bench for raster_stream_gen at H_ACT=8, V_ACT=4, H_BLANK=4,
// V_BLANK=2, DW=8, CHK_LOG2=1 (frame period 72 clocks).
// Expected stream per output clock o, counted from the first vvalid clock:
//   o 0..3 front porch, lines at o=4+12*l .. 11+12*l, gaps between,
//   o 48..71 vertical blanking with frame_done at o=48.
module tb_raster_stream_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  raster_stream_gen_if #(.DW(8)) bif ();

  raster_stream_gen #(
    .H_ACT(8), .V_ACT(4), .H_BLANK(4), .V_BLANK(2), .DW(8), .CHK_LOG2(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, vvalid, hvalid, frame_done, dout}
  function automatic logic [11:0] observe();
    return {bif.busy, bif.vvalid, bif.hvalid, bif.frame_done, bif.dout};
  endfunction

  // Expected {busy, vvalid, hvalid, frame_done, dout} at offset o (0..71) of a frame.
  function automatic logic [11:0] exp_vec(input int o, input int pat);
    logic       vv, hv, fd;
    logic [7:0] d;
    int r, l, p;
    vv = 1'b0; hv = 1'b0; fd = 1'b0; d = 8'h00;
    if (o < 4) begin
      vv = 1'b1;
    end else if (o < 48) begin
      vv = 1'b1;
      r = o - 4;
      l = r / 12;
      p = r % 12;
      if (p < 8) begin
        hv = 1'b1;
        case (pat)
          0:       d = 8'(p);
          1:       d = 8'(l);
          2:       d = (((p >> 1) ^ (l >> 1)) & 1) != 0 ? 8'hFF : 8'h00;
          default: d = 8'h00;
        endcase
      end
    end else begin
      fd = (o == 48);
    end
    return {1'b1, vv, hv, fd, d};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bif.en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    rst = 1'b1;
    bif.en = 1'b1;
    bif.pat_sel = 2'd0;
    repeat (5) begin
      tick();
      obs = observe();
      n_vec++;
      if (obs !== 12'h000) begin
        n_err++;
        $display("FAIL reset_hold got=%h exp=%h", obs, 12'h000);
      end
    end
    bif.en = 1'b0;
    rst = 1'b0;
    repeat (4) begin
      tick();
      obs = observe();
      n_vec++;
      if (obs !== 12'h000) begin
        n_err++;
        $display("FAIL idle_after_reset got=%h exp=%h", obs, 12'h000);
      end
    end
  endtask

  // Two back-to-back h-ramp frames, en dropped during the second.
  task automatic test_hramp();
    logic [11:0] obs, ex;
    int dones = 0;
    bif.pat_sel = 2'd0;
    bif.en = 1'b1;
    tick();
    obs = observe();
    n_vec++;
    if (obs !== 12'h000) begin
      n_err++;
      $display("FAIL hramp_latency got=%h exp=%h", obs, 12'h000);
    end
    for (int o = 0; o < 144; o++) begin
      tick();
      if (o == 100) bif.en = 1'b0;
      obs = observe();
      ex = exp_vec(o % 72, 0);
      if (obs[8]) dones++;
      n_vec++;
      if (obs !== ex) begin
        n_err++;
        $display("FAIL hramp o=%0d got=%h exp=%h", o, obs, ex);
      end
    end
    tick();
    obs = observe();
    n_vec++;
    if (obs !== 12'h000) begin
      n_err++;
      $display("FAIL hramp_idle got=%h exp=%h", obs, 12'h000);
    end
    n_vec++;
    if (dones !== 2) begin
      n_err++;
      $display("FAIL hramp_done_count got=%0d exp=%0d", dones, 2);
    end
  endtask

  task automatic test_checker();
    logic [11:0] obs, ex;
    do_reset();
    bif.pat_sel = 2'd2;
    bif.en = 1'b1;
    tick();
    bif.en = 1'b0;
    for (int o = 0; o < 72; o++) begin
      tick();
      obs = observe();
      ex = exp_vec(o, 2);
      n_vec++;
      if (obs !== ex) begin
        n_err++;
        $display("FAIL checker o=%0d got=%h exp=%h", o, obs, ex);
      end
    end
  endtask

  task automatic test_prbs();
    logic [11:0] obs, ex;
    logic [7:0]  f0 [32];
    logic [7:0]  f1 [32];
    logic [7:0]  head [4];
    int c0 = 0;
    int c1 = 0;
    head[0] = 8'hAC; head[1] = 8'h56; head[2] = 8'hAB; head[3] = 8'h55;
    for (int i = 0; i < 32; i++) begin
      f0[i] = 8'h00;
      f1[i] = 8'h00;
    end
    do_reset();
    bif.pat_sel = 2'd3;
    bif.en = 1'b1;
    tick();
    for (int o = 0; o < 144; o++) begin
      tick();
      if (o == 100) bif.en = 1'b0;
      obs = observe();
      ex = exp_vec(o % 72, 3);
      n_vec++;
      if ((obs & 12'hF00) !== (ex & 12'hF00)) begin
        n_err++;
        $display("FAIL prbs_timing o=%0d got=%h exp=%h", o, obs, ex);
      end
      if (bif.hvalid === 1'b1) begin
        if (o < 72 && c0 < 32) begin f0[c0] = bif.dout; c0++; end
        else if (o >= 72 && c1 < 32) begin f1[c1] = bif.dout; c1++; end
      end else begin
        n_vec++;
        if (bif.dout !== 8'h00) begin
          n_err++;
          $display("FAIL prbs_dout_blank o=%0d got=%h exp=%h", o, bif.dout, 8'h00);
        end
      end
    end
    n_vec++;
    if (c0 !== 32 || c1 !== 32) begin
      n_err++;
      $display("FAIL prbs_pixel_count got=%0d/%0d exp=32/32", c0, c1);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (f0[i] !== head[i] || f1[i] !== head[i]) begin
        n_err++;
        $display("FAIL prbs_head i=%0d got=%h/%h exp=%h", i, f0[i], f1[i], head[i]);
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (f1[i] !== f0[i]) begin
        n_err++;
        $display("FAIL prbs_repeat i=%0d got=%h exp=%h", i, f1[i], f0[i]);
      end
    end
  endtask

  // Single-clock en, a stray en pulse mid line 1, then the frame must finish and park.
  task automatic test_en_drop();
    logic [11:0] obs, ex;
    do_reset();
    bif.pat_sel = 2'd0;
    bif.en = 1'b1;
    tick();
    bif.en = 1'b0;
    for (int o = 0; o < 72; o++) begin
      tick();
      bif.en = (o == 20);
      obs = observe();
      ex = exp_vec(o, 0);
      n_vec++;
      if (obs !== ex) begin
        n_err++;
        $display("FAIL en_drop o=%0d got=%h exp=%h", o, obs, ex);
      end
    end
    bif.en = 1'b0;
    repeat (10) begin
      tick();
      obs = observe();
      n_vec++;
      if (obs !== 12'h000) begin
        n_err++;
        $display("FAIL en_drop_idle got=%h exp=%h", obs, 12'h000);
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [11:0] obs, ex;
    do_reset();
    bif.pat_sel = 2'd0;
    bif.en = 1'b1;
    tick();
    for (int o = 0; o <= 30; o++) begin
      tick();
      obs = observe();
      ex = exp_vec(o, 0);
      n_vec++;
      if (obs !== ex) begin
        n_err++;
        $display("FAIL rst_pre o=%0d got=%h exp=%h", o, obs, ex);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = observe();
    n_vec++;
    if (obs !== 12'h000) begin
      n_err++;
      $display("FAIL rst_abort got=%h exp=%h", obs, 12'h000);
    end
    tick();
    obs = observe();
    n_vec++;
    if (obs !== 12'h000) begin
      n_err++;
      $display("FAIL rst_restart_latency got=%h exp=%h", obs, 12'h000);
    end
    for (int o = 0; o < 72; o++) begin
      tick();
      if (o == 10) bif.en = 1'b0;
      obs = observe();
      ex = exp_vec(o, 0);
      n_vec++;
      if (obs !== ex) begin
        n_err++;
        $display("FAIL rst_restart o=%0d got=%h exp=%h", o, obs, ex);
      end
    end
  endtask

  task automatic test_pat_switch();
    logic [11:0] obs, ex;
    do_reset();
    bif.pat_sel = 2'd0;
    bif.en = 1'b1;
    tick();
    for (int o = 0; o < 144; o++) begin
      tick();
      if (o == 18) bif.pat_sel = 2'd1;
      if (o == 100) bif.en = 1'b0;
      obs = observe();
      ex = exp_vec(o % 72, (o < 72) ? 0 : 1);
      n_vec++;
      if (obs !== ex) begin
        n_err++;
        $display("FAIL pat_switch o=%0d got=%h exp=%h", o, obs, ex);
      end
    end
  endtask

  initial begin
    bif.en = 1'b0;
    bif.pat_sel = 2'd0;
    test_reset();
    test_hramp();
    test_checker();
    test_prbs();
    test_en_drop();
    test_rst_mid_frame();
    test_pat_switch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
